runahead_speculation_resolver: RTL



---
 rtl/runahead_speculation_resolver.sv | 133 +++++++++++++
 1 files changed

// File: rtl/runahead_speculation_resolver.sv
`default_nettype none
// ============================================================================
// Module   : runahead_speculation_resolver
// Purpose  : Drains the speculative clear queue one entry at a time: predicted
//            entries by counting retires, mispredicted ones by a tail rewind.
// Options  : RUNAHEAD_RESOLVER_STATS_EN adds saturating entry statistics.
// Revision : 1.0  initial release
// ============================================================================
module runahead_speculation_resolver #(
  parameter int COUNTERBITWIDTH = 6
) (
  input  logic                       clk,
  input  logic                       async_rst,
  input  logic                       clk_en,
  input  logic                       ClearEntryValid,
  input  logic                       ClearEntryMispredicted,
  input  logic [COUNTERBITWIDTH-1:0] ClearEntryDepth,
  output logic                       ClearEntryACK,
  input  logic                       SpecRetirePulse,
  output logic                       TailRewindREQ,
  output logic [COUNTERBITWIDTH-1:0] TailRewindDepth,
  input  logic                       TailRewindACK,
  output logic [COUNTERBITWIDTH-1:0] RemainingDepth,
  output logic                       ResolverBusy,
  output logic                       OrphanRetireError
`ifdef RUNAHEAD_RESOLVER_STATS_EN
  ,
  output logic [15:0]                ValidatedEntryCount,
  output logic [15:0]                MispredictedEntryCount
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REWIND = 2'd2
  } state_t;

  state_t                       r_state, w_nextState;
  logic [COUNTERBITWIDTH-1:0]   r_remaining, w_nextRemaining;
  logic [COUNTERBITWIDTH-1:0]   r_rewindDepth, w_nextRewindDepth;
  logic                         r_orphan, w_nextOrphan;
  logic                         w_ack;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_rewindDepth <= '0;
      r_orphan      <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_remaining   <= w_nextRemaining;
      r_rewindDepth <= w_nextRewindDepth;
      r_orphan      <= w_nextOrphan;
    end
  end

  // With clk_en low every next value equals the current one and no ACK fires.
  always_comb begin
    w_nextState       = r_state;
    w_nextRemaining   = r_remaining;
    w_nextRewindDepth = r_rewindDepth;
    w_nextOrphan      = r_orphan;
    w_ack             = 1'b0;
    if (clk_en) begin
      case (r_state)
        IDLE: begin
          if (SpecRetirePulse) w_nextOrphan = 1'b1;
          if (ClearEntryValid) begin
            if (ClearEntryDepth == '0) begin
              w_ack = 1'b1;
            end else if (ClearEntryMispredicted) begin
              w_nextRewindDepth = ClearEntryDepth;
              w_nextState       = REWIND;
            end else begin
              w_nextRemaining = ClearEntryDepth;
              w_nextState     = COUNT;
            end
          end
        end
        COUNT: begin
          if (SpecRetirePulse) begin
            if (r_remaining <= COUNTERBITWIDTH'(1)) begin
              w_ack           = (r_remaining == COUNTERBITWIDTH'(1));
              w_nextRemaining = '0;
              w_nextState     = IDLE;
            end else begin
              w_nextRemaining = r_remaining - COUNTERBITWIDTH'(1);
            end
          end
        end
        REWIND: begin
          // Depth register is cleared on exit so the output reads 0 elsewhere.
          if (TailRewindACK) begin
            w_ack             = 1'b1;
            w_nextRewindDepth = '0;
            w_nextState       = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  assign ClearEntryACK     = w_ack;
  assign TailRewindREQ     = (r_state == REWIND);
  assign TailRewindDepth   = r_rewindDepth;
  assign RemainingDepth    = r_remaining;
  assign ResolverBusy      = (r_state != IDLE);
  assign OrphanRetireError = r_orphan;

`ifdef RUNAHEAD_RESOLVER_STATS_EN
  logic [15:0] r_validatedCount, r_mispredictedCount;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_validatedCount    <= '0;
      r_mispredictedCount <= '0;
    end else begin
      if (w_ack && (r_state == COUNT) && (r_validatedCount != 16'hFFFF))
        r_validatedCount <= r_validatedCount + 16'd1;
      if (w_ack && (r_state == REWIND) && (r_mispredictedCount != 16'hFFFF))
        r_mispredictedCount <= r_mispredictedCount + 16'd1;
    end
  end

  assign ValidatedEntryCount    = r_validatedCount;
  assign MispredictedEntryCount = r_mispredictedCount;
`endif

endmodule
`default_nettype wire
